// File: rtl/serial_subtractor.sv
// Multi-cycle two's-complement subtractor: A - B computed as A + ~B + 1, one SLICE-bit slice per clock, LSB first.
// Optional build macro SUB_SATURATE_EN clamps the result on signed overflow instead of wrapping.
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_SUB,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_overflow,
   output logic             data_isNotEqual,
   output logic             data_isLessThan,
   output logic             data_resultRDY,
   output logic             busy
);

   // Handshake: ctrl_SUB is sampled only in IDLE or DONE; an accepted start latches
   // the operands. data_resultRDY pulses for exactly one cycle (DONE); result and
   // flags are valid from that pulse until the next accepted start.
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic [SLICE:0]   slice_sum;
   logic [WIDTH-1:0] diff_next;
   logic [WIDTH-1:0] final_result;
   logic             last_slice;
   logic             ov_next;
   logic             start_ok;

   always_comb begin
      slice_sum = {1'b0, a_q[cnt*SLICE +: SLICE]}
                + {1'b0, ~b_q[cnt*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, carry};
      diff_next = data_result;
      diff_next[cnt*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      last_slice = (cnt == CW'(N - 1));
      ov_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_next[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SUB_SATURATE_EN
      if (ov_next)
         final_result = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         final_result = diff_next;
`else
      final_result = diff_next;
`endif
      start_ok = ctrl_SUB && (state == IDLE || state == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         carry           <= 1'b0;
         a_q             <= '0;
         b_q             <= '0;
         data_result     <= '0;
         data_overflow   <= 1'b0;
         data_isNotEqual <= 1'b0;
         data_isLessThan <= 1'b0;
         data_resultRDY  <= 1'b0;
         busy            <= 1'b0;
      end else if (start_ok) begin
         state          <= RUN;
         a_q            <= data_operandA;
         b_q            <= data_operandB;
         cnt            <= '0;
         carry          <= 1'b1;
         data_resultRDY <= 1'b0;
         busy           <= 1'b1;
      end else begin
         case (state)
            RUN: begin
               carry <= slice_sum[SLICE];
               if (last_slice) begin
                  // Flags always come from the true (unclamped) difference.
                  cnt             <= '0;
                  state           <= DONE;
                  data_result     <= final_result;
                  data_overflow   <= ov_next;
                  data_isNotEqual <= |diff_next;
                  data_isLessThan <= diff_next[WIDTH-1] ^ ov_next;
                  data_resultRDY  <= 1'b1;
                  busy            <= 1'b0;
               end else begin
                  cnt         <= cnt + 1'b1;
                  data_result <= diff_next;
               end
            end
            DONE: begin
               state          <= IDLE;
               data_resultRDY <= 1'b0;
            end
            default: begin
               state          <= IDLE;
               data_resultRDY <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W   = 32;
   localparam int LAT = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         ctrl_SUB = 1'b0;
   logic [W-1:0] data_operandA = '0;
   logic [W-1:0] data_operandB = '0;
   logic [W-1:0] data_result;
   logic         data_overflow;
   logic         data_isNotEqual;
   logic         data_isLessThan;
   logic         data_resultRDY;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(W), .SLICE(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_SUB       (ctrl_SUB),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_overflow  (data_overflow),
      .data_isNotEqual(data_isNotEqual),
      .data_isLessThan(data_isLessThan),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive a start pulse covering exactly one rising edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      data_operandA = a;
      data_operandB = b;
      ctrl_SUB = 1'b1;
      @(posedge clock);
      #1 ctrl_SUB = 1'b0;
   endtask

   task automatic wait_rdy(output int lat);
      lat = 0;
      do begin
         @(posedge clock);
         lat++;
         #1;
      end while (!data_resultRDY && lat < 40);
      if (!data_resultRDY) check("rdy_timeout", 32'd0, 32'd1);
   endtask

   // Reference: exact integer arithmetic on the signed operands.
   task automatic check_model(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      longint       d;
      logic         ov;
      logic [W-1:0] exp_r;
      d  = longint'($signed(a)) - longint'($signed(b));
      ov = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      exp_r = a - b;
`ifdef SUB_SATURATE_EN
      if (ov) exp_r = (d > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      check({tag, "_result"}, data_result, exp_r);
      check({tag, "_ovf"}, {31'd0, data_overflow}, {31'd0, ov});
      check({tag, "_ne"}, {31'd0, data_isNotEqual}, {31'd0, a != b});
      check({tag, "_lt"}, {31'd0, data_isLessThan}, {31'd0, $signed(a) < $signed(b)});
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      logic [W-1:0] held;
      launch(a, b);
      wait_rdy(lat);
      check({tag, "_lat"}, lat, LAT);
      check_model(tag, a, b);
      held = data_result;
      @(posedge clock);
      #1;
      check({tag, "_rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
      check({tag, "_hold"}, data_result, held);
   endtask

   initial begin
      int lat;
      int extra;
      logic [W-1:0] ra, rb;

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      check("reset_result", data_result, 32'd0);
      check("reset_flags", {28'd0, data_overflow, data_isNotEqual, data_isLessThan, busy}, 32'd0);
      check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);

      run_op("sub_10_3", 32'd10, 32'd3);
      run_op("sub_3_10", 32'd3, 32'd10);
      run_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      run_op("ovf_neg", 32'h8000_0000, 32'd1);
      run_op("wrap_0_1", 32'd0, 32'd1);

      // Equal operands, then a back-to-back start issued during DONE.
      launch(32'h1234_5678, 32'h1234_5678);
      wait_rdy(lat);
      check("eq_lat", lat, LAT);
      check_model("eq", 32'h1234_5678, 32'h1234_5678);
      launch(32'd5, 32'd5);
      wait_rdy(lat);
      check("b2b_gap", lat + 1, LAT + 1);
      check_model("b2b", 32'd5, 32'd5);

      // Inputs change and a stray start arrives during RUN.
      @(posedge clock);
      #1;
      launch(32'd100, 32'd1);
      check("run_busy", {31'd0, busy}, 32'd1);
      data_operandA = $urandom;
      data_operandB = $urandom;
      @(posedge clock);
      #1 ctrl_SUB = 1'b1;
      @(posedge clock);
      #1 ctrl_SUB = 1'b0;
      data_operandA = $urandom;
      wait_rdy(lat);
      check("ignore_lat", lat + 2, LAT);
      check_model("ignore", 32'd100, 32'd1);
      extra = 0;
      repeat (12) begin
         @(posedge clock);
         #1 if (data_resultRDY) extra++;
      end
      check("ignore_single_rdy", extra, 0);

      // Reset at RUN cycle 4 aborts with no RDY pulse.
      run_op("pre_rst", 32'd3, 32'd10);
      launch($urandom, $urandom);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      check("rst_result", data_result, 32'd0);
      check("rst_flags", {28'd0, data_overflow, data_isNotEqual, data_isLessThan, busy}, 32'd0);
      check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
      extra = 0;
      repeat (12) begin
         @(posedge clock);
         #1 if (data_resultRDY) extra++;
      end
      check("rst_no_rdy", extra, 0);
      run_op("post_rst", 32'hDEAD_BEEF, 32'h0000_BEEF);

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 6 == 0) rb = ra;
         if (i % 6 == 1) ra = {1'b0, ra[W-2:0]};
         if (i % 6 == 1) rb = {1'b1, rb[W-2:0]};
         run_op($sformatf("rnd%0d", i), ra, rb);
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle two's-complement subtractor computing A − B as A + ~B + 1, one SLICE-bit slice per clock, LSB slice first.
- The borrow/carry between slices is held in a register.
- Sits beside the ALU/multdiv units and uses the same ctrl_/data_ handshake: a start pulse begins the operation and a one-cycle result-ready pulse ends it.
- Produces the difference plus the overflow, not-equal and less-than flags.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per cycle; slice count N = WIDTH/SLICE, default 8.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_SUB  input  1  start pulse; sampled only in IDLE or DONE.
- data_operandA  input  WIDTH  minuend; latched when start is accepted.
- data_operandB  input  WIDTH  subtrahend; latched when start is accepted.
- data_result  output  WIDTH  A − B; valid from data_resultRDY until the next accepted start.
- data_overflow  output  1  signed overflow of A − B.
- data_isNotEqual  output  1  1 when A != B.
- data_isLessThan  output  1  1 when A < B, signed.
- data_resultRDY  output  1  one-cycle pulse; result and flags are valid.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, slice counter=0, carry register=0, operand registers=0.
  - data_result=0, all flags=0, data_resultRDY=0, busy=0.
  - Reset in any state, including mid-RUN, aborts the operation with no RDY pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - ctrl_SUB=1 latches A, B, sets counter=0 and carry=1, and goes to RUN.
  - ctrl_SUB=0 stays in IDLE.
- RUN:
  - Each cycle, slice k = counter computes A[k] + ~B[k] + carry.
  - The SLICE-bit sum is written to result bits [k*SLICE +: SLICE]; the slice carry-out goes to the carry register; counter increments.
  - After the slice with counter = N−1: counter returns to 0 and state goes to DONE.
  - ctrl_SUB during RUN is ignored, with no queuing.
  - Input ports may change freely during RUN; only the latched copies are used.
- DONE (exactly one cycle):
  - data_resultRDY=1 and busy=0.
  - If ctrl_SUB=1, start a new operation and go to RUN (back-to-back supported); otherwise go to IDLE.
- Latency:
  - Start accepted at edge t → data_resultRDY high in the cycle after edge t+N.
  - Default configuration: data_resultRDY is high 8 cycles after the start edge.
  - Throughput: one operation per N+1 cycles.
- data_result and the flags hold their values after DONE until the next accepted start.
- Flag rules (computed combinationally from the final registers, or registered at the final RUN edge; visible identically during DONE):
  - overflow = (A[W−1] != B[W−1]) && (R[W−1] != A[W−1]).
  - isNotEqual = (R != 0).
  - isLessThan = R[W−1] XOR overflow.
  - The final carry-out (no-borrow) is not exported.
- Wrap-around: the result is modulo 2^WIDTH, e.g. 0 − 1 = 0xFFFFFFFF.
- Slices may be built from 4-bit carry-lookahead cells with SLICE=4; slice arithmetic otherwise follows the equations above.

Optional Feature:
- Macro SUB_SATURATE_EN.
- Defined: when overflow=1, data_result is clamped instead of wrapped.
  - A[W−1]=0 gives 0x7FFF_FFFF; A[W−1]=1 gives 0x8000_0000.
  - data_overflow still reads 1.
  - isLessThan and isNotEqual are computed from the unclamped difference.
- Not defined: the result always wraps modulo 2^WIDTH; no clamp logic is present.

Test Plan:
- A=10, B=3, ctrl_SUB pulsed once:
  - data_resultRDY high exactly 8 cycles after the start edge.
  - result=7, overflow=0, isNotEqual=1, isLessThan=0.
- A=3, B=10:
  - result=0xFFFFFFF9, isLessThan=1, isNotEqual=1, overflow=0.
- A=0x7FFFFFFF, B=0xFFFFFFFF:
  - overflow=1, isLessThan=0.
  - result=0x80000000 without SUB_SATURATE_EN, 0x7FFFFFFF with it.
- A=B=0x12345678:
  - result=0, isNotEqual=0, isLessThan=0.
  - Then ctrl_SUB asserted during DONE with A=5, B=5: second RDY 9 cycles after the first.
- Start A=100, B=1; change the inputs and pulse ctrl_SUB during RUN:
  - result=99, with only one RDY pulse.
- Start, then reset asserted at RUN cycle 4:
  - No RDY pulse; all outputs 0 the cycle after reset.
  - A new start afterwards completes correctly.
